// File: rtl/double_gt.sv
// IEEE-754 binary64 greater-than compare: z = (a > b) in numeric order, NaN unordered.
// Latency 1 cycle: z reflects the a/b pair sampled at the previous rising clk edge.
// No backpressure: a new operand pair is accepted every cycle; z holds between edges.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, forces z to 0 and dominates a/b
//   a    - operand A, binary64 (sign[63], exp[62:52], frac[51:0])
//   b    - operand B, binary64, same layout
//   z    - registered result, 1 when a > b
module double_gt (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        z
);

  // Per-operand classification. The magnitude is the raw exponent:fraction
  // field, which for binary64 orders identically to the absolute value for all
  // non-NaN encodings (subnormals, normals and infinity).
  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        zero;
    logic [62:0] mag;
  } fp_class_t;

  function automatic fp_class_t classify(input logic [63:0] v);
    fp_class_t c;
    c.sign = v[63];
    c.nan  = (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
    c.zero = (v[62:0] == 63'd0);
    c.mag  = v[62:0];
    return c;
  endfunction

  fp_class_t a_cls;
  fp_class_t b_cls;
  logic      gt_nxt;

  assign a_cls = classify(a);
  assign b_cls = classify(b);

  // Decision ladder, first match wins. The both-zero rule must precede the
  // sign rules so that +0 > -0 reports false.
  always_comb begin
    gt_nxt = 1'b0;
    if (a_cls.nan || b_cls.nan) begin
      gt_nxt = 1'b0;
    end else if (a_cls.zero && b_cls.zero) begin
      gt_nxt = 1'b0;
    end else if (a_cls.sign != b_cls.sign) begin
      gt_nxt = ~a_cls.sign;
    end else if (!a_cls.sign) begin
      gt_nxt = (a_cls.mag > b_cls.mag);
    end else begin
      // Both negative: the smaller magnitude is the larger number.
      gt_nxt = (a_cls.mag < b_cls.mag);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z <= 1'b0;
    end else begin
      z <= gt_nxt;
    end
  end

endmodule

// File: tb/tb_double_gt.sv
// Self-checking bench for double_gt: directed literal vectors plus random pairs.
// Expected z comes from a real-number model sampled at each rising edge.
// Inputs driven on the falling edge; outputs checked one step after the rising edge.
module tb_double_gt;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        z;

  int n_checks = 0;
  int n_fail   = 0;

  logic exp_q   = 1'b0;
  logic exp_vld = 1'b0;

  double_gt dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .z   (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: numeric compare on real values; any NaN makes the pair unordered.
  function automatic logic model_gt(input logic [63:0] x, input logic [63:0] y);
    real rx;
    real ry;
    rx = $bitstoreal(x);
    ry = $bitstoreal(y);
    if ((rx != rx) || (ry != ry)) return 1'b0;
    return (rx > ry) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, want, $time);
    end
  endtask

  // Model pipeline: what z must be after each rising edge.
  always @(posedge clk) begin
    exp_vld <= 1'b1;
    exp_q   <= rst ? 1'b0 : model_gt(a, b);
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (exp_vld) check("cycle", z, exp_q);
  end

  // Apply one pair for one edge, then check z against a hand-computed literal,
  // and pin the model to the same literal when not in reset.
  task automatic vec(input string name, input logic [63:0] ta, input logic [63:0] tb_v,
                     input logic tr, input logic want);
    @(negedge clk);
    a   = ta;
    b   = tb_v;
    rst = tr;
    @(posedge clk);
    #1;
    check(name, z, want);
    if (!tr) check({name, "_model"}, model_gt(ta, tb_v), want);
  endtask

  function automatic logic [63:0] rand_fp();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v[62:52] = 11'h7FF;             // inf / NaN
      1: v[62:52] = 11'h000;             // zero / subnormal
      2: v[62:0]  = 63'd0;               // signed zero
      3: v[51:0]  = 52'd0;               // exact powers of two, inf
      default: ;
    endcase
    return v;
  endfunction

  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] N1   = 64'hBFF0000000000000;
  localparam logic [63:0] N2   = 64'hC000000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] NZ   = 64'h8000000000000000;
  localparam logic [63:0] MSUB = 64'h0000000000000001;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] NINF = 64'hFFF0000000000000;
  localparam logic [63:0] MAXF = 64'h7FEFFFFFFFFFFFFF;

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;

    vec("reset",          P2,   P1,   1'b1, 1'b0);
    vec("two_gt_one",     P2,   P1,   1'b0, 1'b1);
    vec("one_gt_two",     P1,   P2,   1'b0, 1'b0);
    vec("neg1_gt_neg2",   N1,   N2,   1'b0, 1'b1);
    vec("neg2_gt_neg1",   N2,   N1,   1'b0, 1'b0);
    vec("equal",          P1,   P1,   1'b0, 1'b0);
    vec("pz_gt_nz",       PZ,   NZ,   1'b0, 1'b0);
    vec("nz_gt_pz",       NZ,   PZ,   1'b0, 1'b0);
    vec("minsub_gt_nz",   MSUB, NZ,   1'b0, 1'b1);
    vec("nan_gt_ninf",    QNAN, NINF, 1'b0, 1'b0);
    vec("pinf_gt_nan",    PINF, QNAN, 1'b0, 1'b0);
    vec("pinf_gt_maxf",   PINF, MAXF, 1'b0, 1'b1);
    vec("pos_gt_neg",     P1,   N2,   1'b0, 1'b1);
    vec("b2b_0",          P1,   P2,   1'b0, 1'b0);
    vec("b2b_1",          P2,   P1,   1'b0, 1'b1);
    vec("b2b_2",          QNAN, P1,   1'b0, 1'b0);

    for (int i = 0; i < 5000; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = rand_fp();
      rb = rand_fp();
      // Near-equal pairs exercise the magnitude compare within a sign.
      if ($urandom_range(0, 3) == 0) rb = ra ^ (64'd1 << $urandom_range(0, 62));
      if (i == 2500) begin
        vec("mid_reset", P2, P1, 1'b1, 1'b0);
      end
      @(negedge clk);
      a   = ra;
      b   = rb;
      rst = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
